// File: rtl/banco_registradores_wb.sv
// banco_registradores_wb: register file fed by the writeback stage. It also
// holds a load scoreboard that stalls decode while an operand is waiting on
// an outstanding memory load.
//
// Ports:
//   clock        - single clock, all state updates on posedge
//   reset        - asynchronous, active-high; clears registers and scoreboard
//   RegWrite     - writeback write enable
//   regEscrita   - writeback destination index
//   dadoEscrita  - writeback data (ALU result or memory read data)
//   regLeitura1  - read port 1 index (rs)
//   regLeitura2  - read port 2 index (rt)
//   dadoLido1    - read port 1 data (combinational, with write-through bypass)
//   dadoLido2    - read port 2 data (combinational, with write-through bypass)
//   loadIssue    - a load leaves decode this cycle
//   loadDest     - destination index of that load
//   stall        - combinational; decode must hold because an operand is pending
module banco_registradores_wb #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned WIDTH    = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          RegWrite,
  input  logic [$clog2(NUM_REGS)-1:0]   regEscrita,
  input  logic [WIDTH-1:0]              dadoEscrita,
  input  logic [$clog2(NUM_REGS)-1:0]   regLeitura1,
  input  logic [$clog2(NUM_REGS)-1:0]   regLeitura2,
  output logic [WIDTH-1:0]              dadoLido1,
  output logic [WIDTH-1:0]              dadoLido2,
  input  logic                          loadIssue,
  input  logic [$clog2(NUM_REGS)-1:0]   loadDest,
  output logic                          stall
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  // Entry 0 is kept in the array for uniform indexing but is never written.
  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  logic writeValid;
  logic loadValid;
  logic bypass1;
  logic bypass2;

  // Writes and load sets aimed at register 0 are discarded.
  assign writeValid = RegWrite  && (regEscrita != IDX_W'(0));
  assign loadValid  = loadIssue && (loadDest   != IDX_W'(0));

  // A writeback to the index being read forwards its data in the same cycle.
  assign bypass1 = writeValid && (regEscrita == regLeitura1);
  assign bypass2 = writeValid && (regEscrita == regLeitura2);

  // Architectural register storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (writeValid) begin
      regs[regEscrita] <= dadoEscrita;
    end
  end

  // Load scoreboard; the set is written last so a younger load on the same
  // index wins over the retiring writeback.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (writeValid) begin
        busy[regEscrita] <= 1'b0;
      end
      if (loadValid) begin
        busy[loadDest] <= 1'b1;
      end
    end
  end

  // Read ports: reads are zero while reset is held.
  always_comb begin
    dadoLido1 = '0;
    dadoLido2 = '0;
    if (!reset) begin
      if (regLeitura1 != IDX_W'(0)) begin
        dadoLido1 = bypass1 ? dadoEscrita : regs[regLeitura1];
      end
      if (regLeitura2 != IDX_W'(0)) begin
        dadoLido2 = bypass2 ? dadoEscrita : regs[regLeitura2];
      end
    end
  end

  // Stall depends only on indices, RegWrite and busy; busy[0] is never set.
  always_comb begin
    stall = 1'b0;
    if ((busy[regLeitura1] && !bypass1) || (busy[regLeitura2] && !bypass2)) begin
      stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_banco_registradores_wb.sv
module tb_banco_registradores_wb;

  logic        clock;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  regEscrita;
  logic [31:0] dadoEscrita;
  logic [4:0]  regLeitura1;
  logic [4:0]  regLeitura2;
  logic [31:0] dadoLido1;
  logic [31:0] dadoLido2;
  logic        loadIssue;
  logic [4:0]  loadDest;
  logic        stall;

  int nCompared;
  int nMismatched;

  banco_registradores_wb #(.NUM_REGS(32), .WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .regEscrita (regEscrita),
    .dadoEscrita(dadoEscrita),
    .regLeitura1(regLeitura1),
    .regLeitura2(regLeitura2),
    .dadoLido1  (dadoLido1),
    .dadoLido2  (dadoLido2),
    .loadIssue  (loadIssue),
    .loadDest   (loadDest),
    .stall      (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b1;
    RegWrite    = 1'b0;
    regEscrita  = 5'd0;
    dadoEscrita = 32'h0;
    regLeitura1 = 5'd0;
    regLeitura2 = 5'd0;
    loadIssue   = 1'b0;
    loadDest    = 5'd0;

    tick(); tick();
    regLeitura1 = 5'd5;
    #1;
    check("rst_rd1", dadoLido1, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    reset = 1'b0;

    // Write r5 = 0x1234 and mark r5 busy with a load.
    tick();
    RegWrite = 1'b1; regEscrita = 5'd5; dadoEscrita = 32'h1234;
    #1;
    check("r5_bypass", dadoLido1, 32'h1234);
    tick();
    RegWrite = 1'b0; loadIssue = 1'b1; loadDest = 5'd5;
    #1;
    check("r5_stored", dadoLido1, 32'h1234);
    tick();
    loadIssue = 1'b0;
    #1;
    check("r5_busy_stall", {31'h0, stall}, 32'h1);

    // Mid-run async reset clears data and scoreboard immediately.
    reset = 1'b1;
    #1;
    check("midrst_rd1", dadoLido1, 32'h0);
    check("midrst_stall", {31'h0, stall}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("postrst_rd1", dadoLido1, 32'h0);
    check("postrst_stall", {31'h0, stall}, 32'h0);

    // r7 = 0xDEADBEEF with same-cycle bypass then stored read on port 2.
    RegWrite = 1'b1; regEscrita = 5'd7; dadoEscrita = 32'hDEADBEEF; regLeitura2 = 5'd7;
    #1;
    check("r7_bypass", dadoLido2, 32'hDEADBEEF);
    tick();
    RegWrite = 1'b0; dadoEscrita = 32'h0;
    #1;
    check("r7_stored", dadoLido2, 32'hDEADBEEF);

    // Register 0 ignores writes and load sets.
    RegWrite = 1'b1; regEscrita = 5'd0; dadoEscrita = 32'hFFFFFFFF;
    loadIssue = 1'b1; loadDest = 5'd0; regLeitura1 = 5'd0; regLeitura2 = 5'd0;
    #1;
    check("r0_bypass", dadoLido1, 32'h0);
    check("r0_stall_now", {31'h0, stall}, 32'h0);
    tick();
    RegWrite = 1'b0; loadIssue = 1'b0;
    #1;
    check("r0_rd1", dadoLido1, 32'h0);
    check("r0_rd2", dadoLido2, 32'h0);
    check("r0_stall_after", {31'h0, stall}, 32'h0);

    // Load to r9: stall from N+1 until the writeback cycle.
    loadIssue = 1'b1; loadDest = 5'd9; regLeitura1 = 5'd9;
    #1;
    check("r9_stall_issue", {31'h0, stall}, 32'h0);
    tick();
    loadIssue = 1'b0;
    #1;
    check("r9_stall_n1", {31'h0, stall}, 32'h1);
    tick();
    check("r9_stall_n2", {31'h0, stall}, 32'h1);
    tick();
    RegWrite = 1'b1; regEscrita = 5'd9; dadoEscrita = 32'h55;
    #1;
    check("r9_stall_wb", {31'h0, stall}, 32'h0);
    check("r9_rd_wb", dadoLido1, 32'h55);
    tick();
    RegWrite = 1'b0; dadoEscrita = 32'h0;
    #1;
    check("r9_stall_n4", {31'h0, stall}, 32'h0);
    check("r9_rd_n4", dadoLido1, 32'h55);

    // Same-edge writeback and load on r12: set wins.
    regLeitura1 = 5'd0;
    RegWrite = 1'b1; regEscrita = 5'd12; dadoEscrita = 32'hA5A5A5A5;
    loadIssue = 1'b1; loadDest = 5'd12;
    tick();
    RegWrite = 1'b0; loadIssue = 1'b0; dadoEscrita = 32'h0; regLeitura2 = 5'd12;
    #1;
    check("r12_stall", {31'h0, stall}, 32'h1);
    check("r12_rd2", dadoLido2, 32'hA5A5A5A5);
    tick();
    check("r12_stall_hold", {31'h0, stall}, 32'h1);
    RegWrite = 1'b1; regEscrita = 5'd12; dadoEscrita = 32'h77;
    #1;
    check("r12_stall_wb", {31'h0, stall}, 32'h0);
    check("r12_rd2_wb", dadoLido2, 32'h77);
    tick();
    RegWrite = 1'b0; dadoEscrita = 32'h0;
    #1;
    check("r12_stall_clr", {31'h0, stall}, 32'h0);
    check("r12_rd2_stored", dadoLido2, 32'h77);

    // Both ports: only r3 busy.
    loadIssue = 1'b1; loadDest = 5'd3;
    tick();
    loadIssue = 1'b0; regLeitura1 = 5'd4; regLeitura2 = 5'd3;
    #1;
    check("p2_busy", {31'h0, stall}, 32'h1);
    regLeitura2 = 5'd4;
    #1;
    check("p2_clear", {31'h0, stall}, 32'h0);
    regLeitura1 = 5'd3;
    #1;
    check("p1_busy", {31'h0, stall}, 32'h1);
    // Writeback to r7 must not clear a stall on r3.
    RegWrite = 1'b1; regEscrita = 5'd7; dadoEscrita = 32'h1;
    #1;
    check("p1_other_wb", {31'h0, stall}, 32'h1);
    check("r7_bypass_p2", dadoLido2, 32'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("p1_still_busy", {31'h0, stall}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
